// File: rtl/mem_bus_arbiter.sv
// Arbiter that shares one SRAM-like memory port between instruction fetch and
// load/store. A small in-order ID FIFO steers each response back to the
// requester that issued it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no stalled request, so the owner is the current arbitration winner
// ST_LOCK | request issued but not accepted, so lock_owner holds the bus
module mem_bus_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        bus_req_o,
  output logic        bus_wr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_addr_ok_i,
  input  logic        bus_data_ok_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t               state;
  logic                 lock_owner;   // 1 = data, 0 = inst
  logic [OUTSTANDING-1:0] id_mem;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [SW-1:0]        starve_cnt;

  logic winner;
  logic owner;
  logic slot_free;
  logic grant;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration, issue gating, bus mux and response routing
  always_comb begin
    winner    = data_req_i & ~((starve_cnt == SW'(STARVE_LIMIT)) & inst_req_i);
    owner     = (state == ST_LOCK) ? lock_owner : winner;
    slot_free = (count < CW'(OUTSTANDING));
    bus_req_o = ((state == ST_LOCK) | inst_req_i | data_req_i) & slot_free;
    grant     = bus_req_o & bus_addr_ok_i;
    pop       = bus_data_ok_i & (count != '0);
    head      = id_mem[rd_ptr];

    bus_addr_o  = owner ? data_addr_i  : inst_addr_i;
    bus_wr_o    = owner ? data_wr_i    : 1'b0;
    bus_wstrb_o = (owner & data_wr_i) ? data_wstrb_i : 4'b0000;
    bus_wdata_o = owner ? data_wdata_i : 32'h0;

    inst_addr_ok_o = grant & ~owner;
    data_addr_ok_o = grant & owner;

    inst_data_ok_o = pop & ~head;
    data_data_ok_o = pop & head;
    inst_rdata_o   = bus_rdata_i;
    data_rdata_o   = bus_rdata_i;
  end

  // Lock FSM: hold the stalled owner on the bus until the memory accepts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lock_owner <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus_req_o && !bus_addr_ok_i) begin
            state      <= ST_LOCK;
            lock_owner <= winner;
          end
        end
        ST_LOCK: begin
          if (grant) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // In-order ID FIFO of accepted transactions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) begin
        id_mem[wr_ptr] <= owner;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (grant && !pop)      count <= count + 1'b1;
      else if (!grant && pop) count <= count - 1'b1;
    end
  end

  // Count data grants that pass over a waiting fetch, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!inst_req_i || inst_addr_ok_o) begin
      starve_cnt <= '0;
    end else if (data_addr_ok_o && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a scoreboard of expected response owners is
// filled on each expected grant and drained on every memory response.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic        inst_addr_ok_o, inst_data_ok_o;
  logic [31:0] inst_rdata_o;
  logic        data_req_i = 1'b0, data_wr_i = 1'b0;
  logic [3:0]  data_wstrb_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        data_addr_ok_o, data_data_ok_o;
  logic [31:0] data_rdata_o;
  logic        bus_req_o, bus_wr_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_addr_ok_i = 1'b0, bus_data_ok_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int checks = 0;
  int errors = 0;
  logic sb[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
    .inst_addr_ok_o(inst_addr_ok_o), .inst_data_ok_o(inst_data_ok_o),
    .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_wstrb_i(data_wstrb_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_addr_ok_o(data_addr_ok_o), .data_data_ok_o(data_data_ok_o),
    .data_rdata_o(data_rdata_o),
    .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_addr_ok_i(bus_addr_ok_i), .bus_data_ok_i(bus_data_ok_i),
    .bus_rdata_i(bus_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check response routing against the scoreboard head
  task automatic check_resp(input string tag);
    logic e;
    if (bus_data_ok_i) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_inst_dok"}, {31'b0, inst_data_ok_o}, {31'b0, ~e});
        chk({tag, "_data_dok"}, {31'b0, data_data_ok_o}, {31'b0, e});
        chk({tag, "_rdata"}, e ? data_rdata_o : inst_rdata_o, bus_rdata_i);
      end else begin
        chk({tag, "_inst_dok_empty"}, {31'b0, inst_data_ok_o}, 32'h0);
        chk({tag, "_data_dok_empty"}, {31'b0, data_data_ok_o}, 32'h0);
      end
    end
  endtask

  task automatic step(input string tag,
                      input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [3:0] ds,
                      input logic [31:0] da, input logic [31:0] dd,
                      input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    inst_req_i = ir; inst_addr_i = ia;
    data_req_i = dr; data_wr_i = dw; data_wstrb_i = ds;
    data_addr_i = da; data_wdata_i = dd;
    bus_addr_ok_i = aok; bus_data_ok_i = dok; bus_rdata_i = rd;
    #1;
    check_resp(tag);
  endtask

  // Expect a grant this cycle to the given owner (1 = data) at the given address
  task automatic expect_grant(input string tag, input logic own, input logic [31:0] addr);
    chk({tag, "_bus_req"}, {31'b0, bus_req_o}, 32'h1);
    chk({tag, "_addr"}, bus_addr_o, addr);
    chk({tag, "_inst_aok"}, {31'b0, inst_addr_ok_o}, {31'b0, ~own});
    chk({tag, "_data_aok"}, {31'b0, data_addr_ok_o}, {31'b0, own});
    if (!own) begin
      chk({tag, "_wr0"}, {31'b0, bus_wr_o}, 32'h0);
      chk({tag, "_wstrb0"}, {28'b0, bus_wstrb_o}, 32'h0);
      chk({tag, "_wdata0"}, bus_wdata_o, 32'h0);
    end
    sb.push_back(own);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_bus_req"}, {31'b0, bus_req_o}, 32'h0);
    chk({tag, "_inst_aok"}, {31'b0, inst_addr_ok_o}, 32'h0);
    chk({tag, "_data_aok"}, {31'b0, data_addr_ok_o}, 32'h0);
  endtask

  initial begin
    // Reset state, with a stray response that must be ignored
    #2;
    bus_data_ok_i = 1'b1;
    #1;
    expect_idle("rst");
    chk("rst_inst_dok", {31'b0, inst_data_ok_o}, 32'h0);
    chk("rst_data_dok", {31'b0, data_data_ok_o}, 32'h0);
    @(negedge clk);
    bus_data_ok_i = 1'b0;
    rst_n = 1'b1;

    // 1: single fetch and its response
    step("t1_req", 1, 32'h1C000000, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    expect_grant("t1_grant", 1'b0, 32'h1C000000);
    step("t1_resp", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h02C00421);
    chk("t1_rdata", inst_rdata_o, 32'h02C00421);

    // 2: simultaneous requests, store wins
    step("t2_req", 1, 32'h1C000004, 1, 1, 4'b0011, 32'h80, 32'hDEADBEEF, 1, 0, 0);
    expect_grant("t2_grant", 1'b1, 32'h80);
    chk("t2_wr", {31'b0, bus_wr_o}, 32'h1);
    chk("t2_wstrb", {28'b0, bus_wstrb_o}, 32'h3);
    chk("t2_wdata", bus_wdata_o, 32'hDEADBEEF);
    step("t2_resp", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0);

    // 3: stalled load holds the bus even after data_req drops
    step("t3_c1", 0, 0, 1, 0, 4'hF, 32'h100, 32'h0, 0, 0, 0);
    chk("t3_c1_req", {31'b0, bus_req_o}, 32'h1);
    chk("t3_c1_addr", bus_addr_o, 32'h100);
    chk("t3_c1_wstrb", {28'b0, bus_wstrb_o}, 32'h0);
    chk("t3_c1_daok", {31'b0, data_addr_ok_o}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step("t3_lock", 1, 32'h1C000008, 0, 0, 4'hF, 32'h100, 32'h0, 0, 0, 0);
      chk("t3_lock_req", {31'b0, bus_req_o}, 32'h1);
      chk("t3_lock_addr", bus_addr_o, 32'h100);
      chk("t3_lock_iaok", {31'b0, inst_addr_ok_o}, 32'h0);
      chk("t3_lock_wr", {31'b0, bus_wr_o}, 32'h0);
    end
    step("t3_acc", 1, 32'h1C000008, 0, 0, 4'hF, 32'h100, 32'h0, 1, 0, 0);
    expect_grant("t3_acc", 1'b1, 32'h100);
    step("t3_inst", 1, 32'h1C000008, 0, 0, 4'h0, 32'h100, 32'h0, 1, 0, 0);
    expect_grant("t3_inst", 1'b0, 32'h1C000008);
    step("t3_r1", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h11111111);
    step("t3_r2", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h22222222);

    // 4: outstanding limit, and a pop does not free a slot the same cycle
    step("t4_i", 1, 32'h1C000010, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    expect_grant("t4_i", 1'b0, 32'h1C000010);
    step("t4_d", 0, 0, 1, 0, 4'h0, 32'h200, 0, 1, 0, 0);
    expect_grant("t4_d", 1'b1, 32'h200);
    step("t4_full", 1, 32'h1C000014, 1, 0, 4'h0, 32'h204, 0, 1, 1, 32'h33333333);
    expect_idle("t4_full");
    step("t4_r2", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h44444444);

    // 5: starvation: four data grants, then the fetch is forced, then data again
    for (int i = 0; i < 6; i++) begin
      step("t5", 1, 32'h1C000100 + 32'(i * 4), 1, 0, 4'h0, 32'h300 + 32'(i * 4), 0,
           1, (i > 0), 32'h50 + 32'(i));
      if (i == 4) expect_grant("t5_inst", 1'b0, 32'h1C000100 + 32'(i * 4));
      else        expect_grant("t5_data", 1'b1, 32'h300 + 32'(i * 4));
    end
    step("t5_drain", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h5F);

    // 6: asynchronous reset with two outstanding
    step("t6_i", 1, 32'h1C000200, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    expect_grant("t6_i", 1'b0, 32'h1C000200);
    step("t6_d", 0, 0, 1, 1, 4'hF, 32'h400, 32'h1234, 1, 0, 0);
    expect_grant("t6_d", 1'b1, 32'h400);
    @(negedge clk);
    data_req_i = 0; data_wr_i = 0; bus_addr_ok_i = 0;
    #2;
    rst_n = 1'b0;
    bus_data_ok_i = 1'b1;
    #1;
    sb.delete();
    expect_idle("t6_inrst");
    chk("t6_inrst_idok", {31'b0, inst_data_ok_o}, 32'h0);
    chk("t6_inrst_ddok", {31'b0, data_data_ok_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_data_ok_i = 1'b0;
    step("t6_stray", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h66666666);
    chk("t6_stray_idok", {31'b0, inst_data_ok_o}, 32'h0);
    chk("t6_stray_ddok", {31'b0, data_data_ok_o}, 32'h0);
    // Count must be zero: two issues fit, the third is blocked
    step("t6_a", 1, 32'h1C000300, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    expect_grant("t6_a", 1'b0, 32'h1C000300);
    step("t6_b", 1, 32'h1C000304, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    expect_grant("t6_b", 1'b0, 32'h1C000304);
    step("t6_c", 1, 32'h1C000308, 0, 0, 4'h0, 0, 0, 1, 0, 0);
    expect_idle("t6_c");
    step("t6_r1", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h77);
    step("t6_r2", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h78);
    step("t6_r3", 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h79);

    @(negedge clk);
    bus_data_ok_i = 1'b0;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch requester and the data (EX/MEM load-store) requester.
- Picks a winner and holds it until the address handshake completes.
- Tracks outstanding transactions in order, so each returned read data or write acknowledge goes back to the requester that issued it.
- Sits between the pipeline front-end / MEM stage and the single memory port.

Parameters:
OUTSTANDING, 2, maximum accepted-but-unanswered transactions on the bus (1..4)
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits before instruction is forced

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
inst_req_i  input  1  instruction fetch request
inst_addr_i  input  32  fetch address
inst_addr_ok_o  output  1  fetch request accepted this cycle
inst_data_ok_o  output  1  fetch data valid this cycle
inst_rdata_o  output  32  fetch data
data_req_i  input  1  load/store request
data_wr_i  input  1  1 = store, 0 = load
data_wstrb_i  input  4  store byte enables
data_addr_i  input  32  load/store address
data_wdata_i  input  32  store data
data_addr_ok_o  output  1  load/store request accepted this cycle
data_data_ok_o  output  1  load data valid / store acknowledged this cycle
data_rdata_o  output  32  load data
bus_req_o  output  1  request to memory
bus_wr_o  output  1  write flag
bus_wstrb_o  output  4  byte enables (4'b0000 on reads)
bus_addr_o  output  32  address
bus_wdata_o  output  32  write data
bus_addr_ok_i  input  1  memory accepted request
bus_data_ok_i  input  1  memory response valid (strictly in request order)
bus_rdata_i  input  32  memory read data

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: all of the following are cleared:
  - bus_req_o, inst_addr_ok_o, data_addr_ok_o, inst_data_ok_o, data_data_ok_o = 0
  - ID FIFO empty, starvation counter = 0, lock flag = 0
- Responses after reset:
  - Any bus_data_ok_i arriving while the FIFO is empty is ignored; neither data_ok output pulses.
  - Reset mid-transaction discards all outstanding IDs.
- Arbitration (combinational, used when lock = 0):
  - Winner is data if data_req_i = 1, except when starvation counter == STARVE_LIMIT and inst_req_i = 1; then the winner is inst.
  - Otherwise the winner is inst if inst_req_i = 1.
- Issue gating: bus_req_o = (lock ? 1 : inst_req_i | data_req_i) AND (count < OUTSTANDING).
  - A pop in the same cycle does not free a slot for that cycle's issue.
- Lock: set when bus_req_o = 1 and bus_addr_ok_i = 0. The locked owner (registered) then drives the bus every cycle until bus_addr_ok_i, after which lock clears.
  - The requester must hold its request stable while locked.
  - Lock cannot be entered while the FIFO is full.
- Bus mux:
  - bus_wr_o / bus_wstrb_o / bus_wdata_o come from the data port when owner = data; when owner = inst they are 0 / 4'b0000 / 0.
  - bus_addr_o comes from the owner's address.
- addr_ok routing: owner's addr_ok_o = bus_req_o & bus_addr_ok_i; the other port's addr_ok_o = 0. Combinational, zero-cycle latency.
- ID FIFO: depth OUTSTANDING, 1-bit entries (0 = inst, 1 = data).
  - Push owner ID on bus_req_o & bus_addr_ok_i; pop on bus_data_ok_i with count > 0.
  - Push and pop in the same cycle are both legal: count unchanged, pointers wrap modulo OUTSTANDING.
- Response routing (combinational):
  - inst_data_ok_o = bus_data_ok_i & count > 0 & head == 0.
  - data_data_ok_o = bus_data_ok_i & count > 0 & head == 1.
  - inst_rdata_o and data_rdata_o both equal bus_rdata_i at all times.
- Starvation counter: on each data grant (addr_ok) while inst_req_i = 1, increment, saturating at STARVE_LIMIT. Clear it on an inst grant or whenever inst_req_i = 0.
- No internal pipeline registers: the request path is 0-cycle; response latency is set by memory.

Test Plan:
1. Reset, then inst_req_i = 1 at addr 0x1C000000 with bus_addr_ok_i = 1 → bus_addr_o = 0x1C000000, inst_addr_ok_o = 1 same cycle; a later bus_data_ok_i with rdata 0x02C00421 gives inst_data_ok_o = 1, data_data_ok_o = 0.
2. Both requesting in the same cycle, store to 0x80 with wstrb 4'b0011 → data wins: bus_wr_o = 1, bus_wstrb_o = 4'b0011; inst_addr_ok_o = 0.
3. bus_addr_ok_i held low 3 cycles while data is granted, and data_req_i drops mid-lock → bus_req_o stays 1 with data's address; arbitration only changes after addr_ok.
4. OUTSTANDING = 2: accept inst then data with no responses → bus_req_o = 0 on the third request. Two bus_data_ok_i pulses then give inst_data_ok_o followed by data_data_ok_o, in that order.
5. data_req_i held high with constant addr_ok, inst_req_i high → after 4 data grants the 5th grant goes to inst; the counter then returns to 0.
6. Assert rst_n = 0 asynchronously with 2 outstanding, release, then pulse bus_data_ok_i → both data_ok outputs stay 0 and FIFO count stays 0.
